idu_core_status_ctrl: RTL and testbench

Core-status sequencer for the IDU dispatch path. It watches the dispatcher's exception/WFI detect flag and waits one cycle for the EX-stage resolution: a BRU flush, an exception or a WFI. It then gates fetch, clears the instruction buffer, drains and sleeps on WFI, traps on an exception and sequences the restart. It owns the core_running bit that qualifies the IFU-to-IDU pipe valid and the CSR exception-update pulse.

---
 rtl/idu_core_status_ctrl.sv | 131 +++++++++++++
 tb/tb_idu_core_status_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/idu_core_status_ctrl.sv
// Core-status sequencer: gates fetch around flush/exception/WFI, drains, sleeps, traps and restarts.
// Optional sleep-cycle counter is built only when CORE_SLEEP_CNT_EN is defined.
module idu_core_status_ctrl #(
  parameter int EXCEPTION_NUM = 2,
  parameter int DRAIN_CYCLES  = 3,
  parameter int DRAIN_CNT_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dispatcher_detect_exceptions_wfi,
  input  logic                     iex_idu_bru_flush,
  input  logic                     iex_csr_exception_vld,
  input  logic [EXCEPTION_NUM-1:0] iex_csr_exceptions,
  input  logic                     iex_csr_wfi_vld,
  input  logic                     wakeup_irq,
  input  logic                     trap_restart,
  output logic                     core_running,
  output logic                     instbuffer_clear,
  output logic                     csr_exception_update,
  output logic [EXCEPTION_NUM-1:0] csr_exception_cause,
  output logic                     core_sleep,
  output logic                     core_resume,
  output logic [31:0]              sleep_cycle_cnt
);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_PEND   = 3'd1,
    S_DRAIN  = 3'd2,
    S_SLEEP  = 3'd3,
    S_TRAP   = 3'd4,
    S_RESUME = 3'd5
  } state_e;

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [DRAIN_CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                     wake_q, wake_d;
  logic                     upd_q, upd_d;
  logic [EXCEPTION_NUM-1:0] cause_q, cause_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      drain_cnt_q <= '0;
      wake_q      <= 1'b0;
      upd_q       <= 1'b0;
      cause_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wake_q      <= wake_d;
      upd_q       <= upd_d;
      cause_q     <= cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    wake_d      = wake_q;
    upd_d       = 1'b0;
    cause_d     = cause_q;
    case (state_q)
      S_RUN: begin
        if (dispatcher_detect_exceptions_wfi) state_d = S_PEND;
      end
      S_PEND: begin
        // Flush wins over exception, exception over WFI; nothing resolved is a spurious detect.
        if (iex_idu_bru_flush) begin
          state_d = S_RUN;
        end else if (iex_csr_exception_vld) begin
          state_d = S_TRAP;
          upd_d   = 1'b1;
          cause_d = iex_csr_exceptions;
        end else if (iex_csr_wfi_vld) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
          wake_d      = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // A wake seen in the final drain cycle counts as well as one latched earlier.
        if (drain_cnt_q == '0) begin
          state_d = (wake_q || wakeup_irq) ? S_RESUME : S_SLEEP;
          wake_d  = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
          wake_d      = wake_q || wakeup_irq;
        end
      end
      S_SLEEP: begin
        if (wakeup_irq) state_d = S_RESUME;
      end
      S_TRAP: begin
        if (trap_restart) state_d = S_RESUME;
      end
      S_RESUME: state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  assign core_running         = (state_q == S_RUN);
  assign instbuffer_clear     = (state_q == S_PEND) || (state_q == S_DRAIN) || (state_q == S_TRAP);
  assign core_sleep           = (state_q == S_SLEEP);
  assign core_resume          = (state_q == S_RESUME);
  assign csr_exception_update = upd_q;
  assign csr_exception_cause  = cause_q;

`ifdef CORE_SLEEP_CNT_EN
  logic [31:0] sleep_cnt_q, sleep_cnt_d;

  always_comb begin
    sleep_cnt_d = sleep_cnt_q;
    if (state_q == S_SLEEP) sleep_cnt_d = sleep_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sleep_cnt_q <= '0;
    else     sleep_cnt_q <= sleep_cnt_d;
  end

  assign sleep_cycle_cnt = sleep_cnt_q;
`else
  assign sleep_cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_idu_core_status_ctrl.sv
// Bench for idu_core_status_ctrl: directed vector table, corner sequences, and randomized run vs. a mode model.
module tb_idu_core_status_ctrl;
  localparam int DC = 3;

  localparam int MD_RUN    = 0;
  localparam int MD_PEND   = 1;
  localparam int MD_DRAIN  = 2;
  localparam int MD_SLEEP  = 3;
  localparam int MD_TRAP   = 4;
  localparam int MD_RESUME = 5;

  logic        clk, rst, det, flush, exc_vld, wfi, wake, restart;
  logic [1:0]  exc;
  logic        running, clear, upd, sleep, resume;
  logic [1:0]  cause;
  logic [31:0] scnt;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int          m_mode;
  int          m_drain_seen;
  bit          m_wake_seen;
  bit          m_upd;
  logic [1:0]  m_cause;
  logic [31:0] m_sleep_cnt;

  idu_core_status_ctrl #(.EXCEPTION_NUM(2), .DRAIN_CYCLES(DC), .DRAIN_CNT_W(2)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .dispatcher_detect_exceptions_wfi (det),
    .iex_idu_bru_flush                (flush),
    .iex_csr_exception_vld            (exc_vld),
    .iex_csr_exceptions               (exc),
    .iex_csr_wfi_vld                  (wfi),
    .wakeup_irq                       (wake),
    .trap_restart                     (restart),
    .core_running                     (running),
    .instbuffer_clear                 (clear),
    .csr_exception_update             (upd),
    .csr_exception_cause              (cause),
    .core_sleep                       (sleep),
    .core_resume                      (resume),
    .sleep_cycle_cnt                  (scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, det, flush, exc_vld;
    logic [1:0] exc;
    logic       wfi, wake, restart;
    logic [6:0] want;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [6:0] o(input logic r, input logic c, input logic u,
                                   input logic [1:0] ca, input logic s, input logic rs);
    return {r, c, u, ca, s, rs};
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef CORE_SLEEP_CNT_EN
    return n;
`else
    return (n & 32'd0);
`endif
  endfunction

  task automatic model_step();
    if (rst) begin
      m_mode = MD_RUN; m_drain_seen = 0; m_wake_seen = 0;
      m_upd = 0; m_cause = 2'b00; m_sleep_cnt = 32'd0;
    end else begin
      m_upd = 0;
      case (m_mode)
        MD_RUN:  if (det) m_mode = MD_PEND;
        MD_PEND: begin
          if (flush) m_mode = MD_RUN;
          else if (exc_vld) begin m_mode = MD_TRAP; m_upd = 1; m_cause = exc; end
          else if (wfi) begin m_mode = MD_DRAIN; m_drain_seen = 0; m_wake_seen = 0; end
          else m_mode = MD_RUN;
        end
        MD_DRAIN: begin
          m_drain_seen++;
          if (wake) m_wake_seen = 1;
          if (m_drain_seen == DC) m_mode = m_wake_seen ? MD_RESUME : MD_SLEEP;
        end
        MD_SLEEP: begin
          m_sleep_cnt = m_sleep_cnt + 32'd1;
          if (wake) m_mode = MD_RESUME;
        end
        MD_TRAP:   if (restart) m_mode = MD_RESUME;
        default:   m_mode = MD_RUN;
      endcase
    end
  endtask

  function automatic logic [6:0] model_vec();
    return {m_mode == MD_RUN,
            (m_mode == MD_PEND) || (m_mode == MD_DRAIN) || (m_mode == MD_TRAP),
            m_upd, m_cause, m_mode == MD_SLEEP, m_mode == MD_RESUME};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    rst = 0; det = 0; flush = 0; exc_vld = 0; exc = 2'b00; wfi = 0; wake = 0; restart = 0;
  endtask

  task automatic chk7(input string name, input logic [6:0] want);
    logic [6:0] got;
    got = {running, clear, upd, cause, sleep, resume};
    n_total++;
    if (got !== want)
      $display("FAIL %s: got run/clr/upd/cause/slp/res=%b required %b", name, got, want);
    else n_pass++;
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) $display("FAIL %s: got %0d required %0d", name, got, want);
    else n_pass++;
  endtask

  initial begin
    idle_in();
    //          rst det fl ev exc   wfi wk rs  expected outputs
    tbl[0]  = '{1, 0, 0, 0, 2'b00, 0, 0, 0, o(1,0,0,2'b00,0,0)};
    tbl[1]  = '{0, 1, 0, 0, 2'b00, 0, 0, 0, o(0,1,0,2'b00,0,0)};
    tbl[2]  = '{0, 0, 1, 0, 2'b00, 0, 0, 0, o(1,0,0,2'b00,0,0)};
    tbl[3]  = '{0, 0, 0, 0, 2'b00, 0, 0, 0, o(1,0,0,2'b00,0,0)};
    tbl[4]  = '{0, 1, 0, 0, 2'b00, 0, 0, 0, o(0,1,0,2'b00,0,0)};
    tbl[5]  = '{0, 0, 0, 1, 2'b10, 0, 0, 0, o(0,1,1,2'b10,0,0)};
    tbl[6]  = '{0, 0, 0, 0, 2'b00, 0, 0, 0, o(0,1,0,2'b10,0,0)};
    tbl[7]  = '{0, 0, 0, 0, 2'b00, 0, 1, 0, o(0,1,0,2'b10,0,0)};
    tbl[8]  = '{0, 0, 0, 0, 2'b00, 0, 0, 1, o(0,0,0,2'b10,0,1)};
    tbl[9]  = '{0, 0, 0, 0, 2'b00, 0, 0, 0, o(1,0,0,2'b10,0,0)};
    tbl[10] = '{0, 0, 0, 0, 2'b00, 0, 0, 1, o(1,0,0,2'b10,0,0)};
    tbl[11] = '{0, 1, 0, 0, 2'b00, 0, 0, 0, o(0,1,0,2'b10,0,0)};
    tbl[12] = '{0, 0, 0, 1, 2'b01, 1, 0, 0, o(0,1,1,2'b01,0,0)};
    tbl[13] = '{0, 0, 0, 0, 2'b00, 0, 0, 1, o(0,0,0,2'b01,0,1)};
    tbl[14] = '{0, 0, 0, 0, 2'b00, 0, 0, 0, o(1,0,0,2'b01,0,0)};
    tbl[15] = '{0, 1, 0, 0, 2'b00, 0, 0, 0, o(0,1,0,2'b01,0,0)};
    tbl[16] = '{0, 0, 1, 1, 2'b10, 1, 0, 0, o(1,0,0,2'b01,0,0)};
    tbl[17] = '{0, 1, 0, 0, 2'b00, 0, 0, 0, o(0,1,0,2'b01,0,0)};

    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; det = tbl[i].det; flush = tbl[i].flush; exc_vld = tbl[i].exc_vld;
      exc = tbl[i].exc; wfi = tbl[i].wfi; wake = tbl[i].wake; restart = tbl[i].restart;
      tick();
      chk7($sformatf("vec%0d", i), tbl[i].want);
    end
    // spurious detect: nothing resolved in PEND returns to RUN
    idle_in(); tick(); chk7("spurious_run", o(1,0,0,2'b01,0,0));

    // WFI: three drain cycles, sleep, wake after five sleep cycles
    det = 1; tick(); chk7("wfi_pend", o(0,1,0,2'b01,0,0));
    det = 0; wfi = 1; tick(); chk7("wfi_drain1", o(0,1,0,2'b01,0,0));
    wfi = 0; tick(); chk7("wfi_drain2", o(0,1,0,2'b01,0,0));
    tick(); chk7("wfi_drain3", o(0,1,0,2'b01,0,0));
    tick(); chk7("wfi_sleep_entry", o(0,0,0,2'b01,1,0));
    chk32("sleep_cnt_entry", scnt, exp_cnt(32'd0));
    for (int i = 0; i < 4; i++) begin
      tick(); chk7($sformatf("wfi_sleep%0d", i), o(0,0,0,2'b01,1,0));
    end
    wake = 1; tick(); chk7("wfi_resume", o(0,0,0,2'b01,0,1));
    chk32("sleep_cnt_5", scnt, exp_cnt(32'd5));
    wake = 0; tick(); chk7("wfi_run", o(1,0,0,2'b01,0,0));
    chk32("sleep_cnt_hold", scnt, exp_cnt(32'd5));

    // wake during 2nd drain cycle skips SLEEP entirely
    det = 1; tick(); chk7("wk_pend", o(0,1,0,2'b01,0,0));
    det = 0; wfi = 1; tick(); chk7("wk_drain1", o(0,1,0,2'b01,0,0));
    wfi = 0; tick(); chk7("wk_drain2", o(0,1,0,2'b01,0,0));
    wake = 1; tick(); chk7("wk_drain3", o(0,1,0,2'b01,0,0));
    wake = 0; tick(); chk7("wk_resume", o(0,0,0,2'b01,0,1));
    tick(); chk7("wk_run", o(1,0,0,2'b01,0,0));
    chk32("wk_cnt", scnt, exp_cnt(32'd5));

    // reset while sleeping
    det = 1; tick();
    det = 0; wfi = 1; tick();
    wfi = 0; tick(); tick(); tick(); tick();
    chk7("rs_sleep", o(0,0,0,2'b01,1,0));
    rst = 1; tick(); chk7("rs_reset", o(1,0,0,2'b00,0,0));
    chk32("rs_cnt", scnt, 32'd0);
    rst = 0; tick(); chk7("rs_run", o(1,0,0,2'b00,0,0));

    // randomized run against the mode model
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 149) == 0);
      det     = ($urandom_range(0, 9) < 3);
      flush   = ($urandom_range(0, 9) < 2);
      exc_vld = ($urandom_range(0, 9) < 2);
      exc     = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      wfi     = ($urandom_range(0, 9) < 4);
      wake    = ($urandom_range(0, 19) < 3);
      restart = ($urandom_range(0, 9) < 2);
      tick();
      chk7($sformatf("rand%0d", c), model_vec());
      chk32($sformatf("rand_cnt%0d", c), scnt, exp_cnt(m_sleep_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
